// File: rtl/branch_unit.sv
// branch_unit: RV32I branch execution stage.
// It evaluates the branch condition and the target/next PC for each accepted
// branch. Results wait in a small circular result queue until the CDB grants
// the head entry. A flush empties the queue.
// Optional build macro: BRANCH_UNIT_STATS_EN adds the retired/taken counters
// stat_total and stat_taken.
module branch_unit #(
  parameter int         DEPTH       = 2,
  parameter logic [5:0] INVALID_ROB = 6'b010000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  issue_robNum,
  input  logic [2:0]  issue_subType,
  input  logic [31:0] issue_data1,
  input  logic [31:0] issue_data2,
  input  logic [31:0] issue_pc,
  input  logic [31:0] issue_imm,
  input  logic        flush,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic [5:0]  robNum_out,
  output logic        taken_out,
  output logic [31:0] target_out,
  output logic [31:0] nextpc_out,
  output logic        err_out
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0] stat_total,
  output logic [31:0] stat_taken
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;

  logic [5:0]  q_rob    [DEPTH];
  logic        q_taken  [DEPTH];
  logic [31:0] q_target [DEPTH];
  logic [31:0] q_nextpc [DEPTH];
  logic        q_err    [DEPTH];

  logic        op_eq;
  logic        op_lt_s;
  logic        op_lt_u;
  logic        cmp_taken;
  logic        cmp_err;
  logic [31:0] cmp_target;
  logic [31:0] pc_plus4;
  logic [31:0] cmp_nextpc;
  logic        push;
  logic        pop;

  assign op_eq   = (issue_data1 == issue_data2);
  assign op_lt_s = ($signed(issue_data1) < $signed(issue_data2));
  assign op_lt_u = (issue_data1 < issue_data2);

  // Condition select by funct3; the unused encodings 010/011 flag an error.
  always_comb begin
    cmp_taken = 1'b0;
    cmp_err   = 1'b0;
    case (issue_subType)
      3'b000:  cmp_taken = op_eq;
      3'b001:  cmp_taken = !op_eq;
      3'b100:  cmp_taken = op_lt_s;
      3'b101:  cmp_taken = !op_lt_s;
      3'b110:  cmp_taken = op_lt_u;
      3'b111:  cmp_taken = !op_lt_u;
      default: cmp_err   = 1'b1;
    endcase
  end

  assign cmp_target = issue_pc + issue_imm;
  assign pc_plus4   = issue_pc + 32'd4;
  assign cmp_nextpc = cmp_taken ? cmp_target : pc_plus4;

  // A grant never frees a slot in the same cycle, so a full queue stalls issue.
  assign issue_ready = (count < FULL_CNT) && !flush;
  assign cdb_req     = (count != '0);
  assign push        = issue_valid && issue_ready;
  assign pop         = cdb_req && cdb_grant && !flush;

  // Queue occupancy and pointer bookkeeping; reset and flush both empty it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result storage. It needs no reset because the outputs are masked while empty.
  always_ff @(posedge clock) begin
    if (push) begin
      q_rob[tail_ptr]    <= issue_robNum;
      q_taken[tail_ptr]  <= cmp_taken;
      q_target[tail_ptr] <= cmp_target;
      q_nextpc[tail_ptr] <= cmp_nextpc;
      q_err[tail_ptr]    <= cmp_err;
    end
  end

  assign robNum_out = cdb_req ? q_rob[head_ptr]    : INVALID_ROB;
  assign taken_out  = cdb_req ? q_taken[head_ptr]  : 1'b0;
  assign target_out = cdb_req ? q_target[head_ptr] : 32'd0;
  assign nextpc_out = cdb_req ? q_nextpc[head_ptr] : 32'd0;
  assign err_out    = cdb_req ? q_err[head_ptr]    : 1'b0;

`ifdef BRANCH_UNIT_STATS_EN
  // Retirement counters; they survive flushes and clear only on reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (pop) begin
      stat_total <= stat_total + 32'd1;
      if (q_taken[head_ptr]) stat_taken <= stat_taken + 32'd1;
    end
  end
`endif

endmodule
